// File: rtl/cnt_sched_pkg.sv
// Shared state encodings and default sizing for the cnt_sched counter scheduler.
// Optional abort support is enabled with CNT_SCHED_ABORT_EN.
package cnt_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_REQ_DEFAULT = 4;
    localparam int CW_DEFAULT    = 4;

endpackage

// File: rtl/cnt_sched_rr_pick.sv
// Combinational round-robin selector: first set request scanning upward from
// last+1 and wrapping, so the previous owner has lowest priority.
module rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    always_comb begin
        logic [IW-1:0] cand;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = '0;
        // k = N_REQ lands back on last itself, giving it the lowest priority.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(last) + k) % N_REQ);
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/cnt_sched.sv
// Round-robin scheduler sharing one up-counter between N_REQ requesters.
// Define CNT_SCHED_ABORT_EN to add the per-requester abort input.
module cnt_sched
    import cnt_sched_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEFAULT,
    parameter  int CW    = CW_DEFAULT,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*CW-1:0] len,
    output logic [N_REQ-1:0]    grant,
    output logic [N_REQ-1:0]    done,
    output logic                busy,
    output logic [CW-1:0]       cnt
`ifdef CNT_SCHED_ABORT_EN
    ,
    input  logic [N_REQ-1:0]    abort
`endif
);

    state_t             state_reg, state_next;
    logic [N_REQ-1:0]   grant_reg, grant_next;
    logic [N_REQ-1:0]   done_reg, done_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [CW-1:0]      len_q_reg, len_q_next;
    logic [IW-1:0]      last_reg, last_next;
    logic [IW-1:0]      owner_reg, owner_next;
    logic               busy_reg, busy_next;

    logic [N_REQ-1:0]   pick_onehot;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;
    logic               abort_hit;
    logic [CW-1:0]      len_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_len
            assign len_arr[gi] = len[gi*CW +: CW];
        end
    endgenerate

`ifdef CNT_SCHED_ABORT_EN
    // Only the current owner's abort matters, and grant_reg is zero outside RUN.
    assign abort_hit = |(abort & grant_reg);
`else
    assign abort_hit = 1'b0;
`endif

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req),
        .last   (last_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        done_next  = '0;
        cnt_next   = cnt_reg;
        len_q_next = len_q_reg;
        last_next  = last_reg;
        owner_next = owner_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next = RUN;
                    grant_next = pick_onehot;
                    cnt_next   = '0;
                    len_q_next = len_arr[pick_idx];
                    owner_next = pick_idx;
                end
            end
            RUN: begin
                if (abort_hit) begin
                    state_next = IDLE;
                    grant_next = '0;
                    cnt_next   = '0;
                    last_next  = owner_reg;
                end else if (cnt_reg == len_q_reg) begin
                    state_next = DONE;
                    done_next  = grant_reg;
                    grant_next = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
                last_next  = owner_reg;
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                cnt_next   = '0;
            end
        endcase
        busy_next = (state_next == RUN) || (state_next == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            done_reg  <= '0;
            cnt_reg   <= '0;
            len_q_reg <= '0;
            last_reg  <= IW'(N_REQ - 1);
            owner_reg <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            done_reg  <= done_next;
            cnt_reg   <= cnt_next;
            len_q_reg <= len_q_next;
            last_reg  <= last_next;
            owner_reg <= owner_next;
            busy_reg  <= busy_next;
        end
    end

    assign grant = grant_reg;
    assign done  = done_reg;
    assign cnt   = cnt_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_cnt_sched.sv
// Directed self-checking bench for cnt_sched: single run, round-robin order,
// full-width count, mid-run reset, len change mid-run and optional abort.
module tb_cnt_sched;

    localparam int N  = 4;
    localparam int CW = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req   = '0;
    logic [N*CW-1:0] len = '0;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic          busy;
    logic [CW-1:0] cnt;
`ifdef CNT_SCHED_ABORT_EN
    logic [N-1:0]  abort = '0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cnt_sched #(
        .N_REQ (N),
        .CW    (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .len   (len),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .cnt   (cnt)
`ifdef CNT_SCHED_ABORT_EN
        ,
        .abort (abort)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [N-1:0] g, input logic [N-1:0] d,
                           input logic [CW-1:0] c, input logic b);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".done"},  32'(done),  32'(d));
        chk({tag, ".cnt"},   32'(cnt),   32'(c));
        chk({tag, ".busy"},  32'(busy),  32'(b));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] exp_g;

        #12;
        chk_out("reset", 4'b0000, 4'b0000, 4'h0, 1'b0);
        step();
        rst_n = 1'b1;

        // Single request, len0 = 3
        len = 16'h0003;
        req = 4'b0001;
        step();
        chk_out("single.c1", 4'b0001, 4'b0000, 4'h0, 1'b1);
        req = 4'b0000;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_out($sformatf("single.c%0d", i + 1), 4'b0001, 4'b0000, CW'(i), 1'b1);
        end
        step();
        chk_out("single.done", 4'b0000, 4'b0001, 4'h3, 1'b1);
        step();
        chk_out("single.idle", 4'b0000, 4'b0000, 4'h0, 1'b0);

        // Round-robin, all requesters, len = 0
        do_reset();
        len = 16'h0000;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << (i % 4);
            step();
            chk_out($sformatf("rr%0d.grant", i), exp_g, 4'b0000, 4'h0, 1'b1);
            step();
            chk_out($sformatf("rr%0d.done", i), 4'b0000, exp_g, 4'h0, 1'b1);
            step();
            chk_out($sformatf("rr%0d.idle", i), 4'b0000, 4'b0000, 4'h0, 1'b0);
        end
        req = 4'b0000;

        // Full-width count on requester 2
        do_reset();
        len = 16'h0F00;
        req = 4'b0100;
        step();
        chk_out("wide.c0", 4'b0100, 4'b0000, 4'h0, 1'b1);
        req = 4'b0000;
        for (int i = 1; i <= 15; i++) begin
            step();
            chk($sformatf("wide.cnt%0d", i), 32'(cnt), 32'(i));
        end
        chk("wide.grant15", 32'(grant), 32'h4);
        step();
        chk_out("wide.done", 4'b0000, 4'b0100, 4'hF, 1'b1);
        step();
        chk_out("wide.idle", 4'b0000, 4'b0000, 4'h0, 1'b0);

        // Reset mid-run; last is 2 beforehand, so only a real reset makes 0 win over 3
        len = 16'h0005;
        req = 4'b0001;
        step();
        chk("rst.g", 32'(grant), 32'h1);
        req = 4'b0000;
        step();
        step();
        chk("rst.cnt2", 32'(cnt), 32'h2);
        rst_n = 1'b0;
        #1;
        chk_out("rst.async", 4'b0000, 4'b0000, 4'h0, 1'b0);
        len = 16'h0000;
        req = 4'b1001;
        step();
        chk_out("rst.held", 4'b0000, 4'b0000, 4'h0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_out("rst.regrant", 4'b0001, 4'b0000, 4'h0, 1'b1);
        req = 4'b0000;
        step();
        chk_out("rst.done", 4'b0000, 4'b0001, 4'h0, 1'b1);
        step();

        // len1 changes 6 -> 1 mid-run; the run still ends at 6
        len = 16'h0060;
        req = 4'b0010;
        step();
        chk_out("len.c0", 4'b0010, 4'b0000, 4'h0, 1'b1);
        req = 4'b0000;
        step();
        step();
        chk("len.cnt2", 32'(cnt), 32'h2);
        len = 16'h0010;
        for (int i = 3; i <= 6; i++) begin
            step();
            chk_out($sformatf("len.c%0d", i), 4'b0010, 4'b0000, CW'(i), 1'b1);
        end
        step();
        chk_out("len.done", 4'b0000, 4'b0010, 4'h6, 1'b1);
        step();
        chk_out("len.idle", 4'b0000, 4'b0000, 4'h0, 1'b0);

`ifdef CNT_SCHED_ABORT_EN
        // Abort requester 1 at cnt = 1; requester 2 is served next
        do_reset();
        len = 16'h0050;
        req = 4'b0110;
        step();
        chk_out("ab.c0", 4'b0010, 4'b0000, 4'h0, 1'b1);
        abort = 4'b0100;
        step();
        chk_out("ab.ignored", 4'b0010, 4'b0000, 4'h1, 1'b1);
        abort = 4'b0010;
        step();
        chk_out("ab.cut", 4'b0000, 4'b0000, 4'h0, 1'b0);
        abort = 4'b0000;
        step();
        chk_out("ab.next", 4'b0100, 4'b0000, 4'h0, 1'b1);
        req = 4'b0000;
        step();
        chk_out("ab.done2", 4'b0000, 4'b0100, 4'h0, 1'b1);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnt_sched.md
# cnt_sched

Round-robin scheduler that time-shares one up-counter between `N_REQ` requesters. Each requester presents a terminal count and holds a request. The block grants the counter to one requester at a time and runs it from 0 up to that terminal count. It then returns a one-cycle done pulse and rotates priority to the next requester. It sits between client logic that needs timed intervals and the single counter datapath, so clients never drive the counter directly.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, valid range 2..8.
- `CW`, default 4: counter and terminal-count width.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request level.
- `len`  in  N_REQ*CW  terminal counts; requester i uses bits [i*CW +: CW].
- `grant`  out  N_REQ  one-hot owner while in RUN; 0 otherwise.
- `done`  out  N_REQ  one-hot, one-cycle completion pulse.
- `busy`  out  1  high in RUN or DONE.
- `cnt`  out  CW  current counter value.
- `abort`  in  N_REQ  per-requester cancel; exists only with `CNT_SCHED_ABORT_EN`.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE, no `req` bit set: stay in IDLE.
- IDLE, any `req` bit set:
  - Pick winner w: the first set bit scanning upward, wrapping, from `last+1`.
  - Next edge: state <= RUN, `grant` <= onehot(w), `cnt` <= 0, `len_q` <= len[w].
- RUN, `cnt` != `len_q`: `cnt` <= `cnt` + 1.
- RUN, `cnt` == `len_q`:
  - Next edge: state <= DONE, `done` <= onehot(w), `grant` <= 0, `cnt` held.
- DONE:
  - Next edge: state <= IDLE, `done` <= 0, `cnt` <= 0, `last` <= w.
- `len` is sampled only at grant. Later changes to `len` do not affect a running count.
- `req` is a level and is not re-examined during RUN or DONE. Dropping `req` mid-run does not cancel the run.
- A requester still asserting `req` after its done pulse is re-eligible. It is served only after every other pending requester (round-robin).
- Width rule: `cnt` never exceeds `len_q`, so it never wraps. `len` = all-ones gives 2^CW RUN cycles.
- `busy` = (state == RUN) or (state == DONE).
- Reset, including mid-operation: state IDLE; `grant`, `done`, `cnt`, `len_q` = 0; `busy` = 0; `last` = N_REQ-1, so requester 0 has first priority. Any run in progress is discarded with no done pulse.

## Timing
- Requests seen in IDLE at cycle k give `grant` at k+1, with `cnt` = 0 at k+1.
- `cnt` = `len_q` at cycle k+1+len.
- `done` is high at cycle k+2+len; `grant` is low at that same cycle.
- State is IDLE again at k+3+len.
- The RUN phase lasts exactly len+1 cycles. len = 0 gives one RUN cycle.
- Back-to-back grants to different requesters are spaced len+3 cycles apart.
- At most one bit of `grant` and one bit of `done` is ever set. `grant` and `done` are never high in the same cycle.

## Configuration
- Macro: `CNT_SCHED_ABORT_EN`.
- Defined:
  - The `abort` port exists.
  - `abort[w]` high in RUN takes effect at the next edge: state <= IDLE, `grant` <= 0, `cnt` <= 0, `last` <= w, and no done pulse.
  - `abort` bits of non-owners are ignored, as is `abort` in IDLE or DONE.
  - `abort[w]` in the same cycle as `cnt` == `len_q`: abort wins and no done pulse is issued.
- Undefined: there is no `abort` port, and every granted run completes with a done pulse.

## Structure
- Package `cnt_sched_pkg` holds the state encodings (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) and the default `N_REQ` and `CW` constants.
- Sub-module `rr_pick`: combinational round-robin selector.
  - Inputs: `req` and `last`.
  - Outputs: one-hot winner and its index.
  - Instantiated once.
- The counter, the `len_q` register and the FSM stay in `cnt_sched`.

## Test plan
- Single request: after reset, req = 0001 with len0 = 3 → grant = 0001 for cycles 1..4 with `cnt` 0,1,2,3; done = 0001 at cycle 5; IDLE at cycle 6.
- Round-robin: req = 1111 held, all len = 0 → grant order 0,1,2,3,0, with successive grants spaced 3 cycles apart.
- Boundary: len2 = 4'hF, only req[2] set → 16 RUN cycles, `cnt` peaks at 15 with no wrap, then a single done[2] pulse.
- Reset mid-run: assert `rst_n` = 0 while `cnt` = 2 of len = 5 → outputs go to 0 immediately; no done pulse; next arbitration starts from requester 0.
- `len` change mid-run: len1 changes 6 → 1 at `cnt` = 2 → the run still ends at `cnt` = 6.
- With `CNT_SCHED_ABORT_EN`: abort[1] at `cnt` = 1 of len = 5 → `grant` = 0 on the next cycle, no done pulse, and the next grant goes to requester 2 if it is requesting.
